axi_rd_arbiter: RTL and testbench

//  Shares one AXI read channel (AR/R) between the inst and data SRAM-like ports of the sram2axi bridge.

---
 rtl/axi_rd_arbiter_if.sv | 36 +++
 rtl/axi_rd_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_if.sv
// AXI read channel (AR/R) bundle shared by the read arbiter
// and whatever AXI slave sits behind it.
interface axi_rd_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize,
    output arburst, arlock, arcache, arprot,
    output arvalid, rready,
    input  arready, rid, rdata, rresp,
    input  rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize,
    input  arburst, arlock, arcache, arprot,
    input  arvalid, rready,
    output arready, rid, rdata, rresp,
    output rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin inst/data read arbiter onto one AXI AR/R channel,
// with per-ID outstanding counters and read-after-write hold-off.
module axi_rd_arbiter #(
  parameter int         MAX_OUTST = 2,
  parameter logic [3:0] INST_ID   = 4'd0,
  parameter logic [3:0] DATA_ID   = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        wr_pending,
  input  logic [31:0] wr_pending_addr,
  output logic        rd_err,
  axi_rd_arbiter_if.master axi
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic {IDLE, AR_WAIT} state_t;

  state_t      state;
  cnt_t        cnt_inst;
  cnt_t        cnt_data;
  logic        rr_data;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size;
  logic        ar_valid;
  logic        r_ready;

  logic pend_inst;
  logic pend_data;
  logic inst_room;
  logic data_room;
  logic raw_hit;
  logic inst_el;
  logic data_el;
  logic idle;
  logic grant_inst;
  logic grant_data;
  logic ar_fire;
  logic inc_inst;
  logic inc_data;
  logic beat;
  logic rid_inst;
  logic rid_data;
  logic hit_inst;
  logic hit_data;
  logic bad_beat;
  logic unused;

  // A latched AR not yet handed to the slave still occupies a slot.
  assign pend_inst = (state == AR_WAIT) && (ar_id == INST_ID);
  assign pend_data = (state == AR_WAIT) && (ar_id == DATA_ID);
  assign inst_room = (32'(cnt_inst) + 32'(pend_inst))
                   < 32'(MAX_OUTST);
  assign data_room = (32'(cnt_data) + 32'(pend_data))
                   < 32'(MAX_OUTST);

  // Same word as the in-flight write: wait for the write to land.
  assign raw_hit = wr_pending
                && (wr_pending_addr[31:2] == data_sram_addr[31:2]);

  assign inst_el = inst_sram_req && inst_room;
  assign data_el = data_sram_req && !data_sram_wr
                && data_room && !raw_hit;

  assign idle       = (state == IDLE) && !reset;
  assign grant_inst = idle && inst_el && (!data_el || rr_data);
  assign grant_data = idle && data_el && (!inst_el || !rr_data);

  assign inst_sram_addr_ok = grant_inst;
  assign data_sram_addr_ok = grant_data;

  assign ar_fire  = (state == AR_WAIT) && axi.arready;
  assign inc_inst = ar_fire && (ar_id == INST_ID);
  assign inc_data = ar_fire && (ar_id == DATA_ID);

  assign beat     = axi.rvalid && r_ready;
  assign rid_inst = (axi.rid == INST_ID);
  assign rid_data = (axi.rid == DATA_ID);
  assign hit_inst = beat && rid_inst && (cnt_inst != '0);
  assign hit_data = beat && rid_data && (cnt_data != '0);
  assign bad_beat = beat && ((axi.rresp != 2'b00)
                  || !(rid_inst || rid_data)
                  || (rid_inst && (cnt_inst == '0))
                  || (rid_data && (cnt_data == '0)));

  assign axi.arid    = ar_id;
  assign axi.araddr  = ar_addr;
  assign axi.arsize  = ar_size;
  assign axi.arvalid = ar_valid;
  assign axi.arlen   = 8'd0;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.rready  = r_ready;

  // Single-beat reads: rlast carries no information here.
  assign unused = ^{axi.rlast, wr_pending_addr[1:0]};

  // AR issue FSM: latch the granted request, hold it until arready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ar_valid <= 1'b0;
      ar_addr  <= '0;
      ar_id    <= '0;
      ar_size  <= '0;
      rr_data  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant_inst: begin
              ar_addr  <= inst_sram_addr;
              ar_size  <= {1'b0, inst_sram_size};
              ar_id    <= INST_ID;
              ar_valid <= 1'b1;
              rr_data  <= 1'b0;
              state    <= AR_WAIT;
            end
            grant_data: begin
              ar_addr  <= data_sram_addr;
              ar_size  <= {1'b0, data_sram_size};
              ar_id    <= DATA_ID;
              ar_valid <= 1'b1;
              rr_data  <= 1'b1;
              state    <= AR_WAIT;
            end
            default: ;
          endcase
        end
        AR_WAIT: begin
          if (axi.arready) begin
            ar_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding reads per ID: up on AR handshake, down on R beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_inst <= '0;
      cnt_data <= '0;
    end else begin
      case ({inc_inst, hit_inst})
        2'b10:   cnt_inst <= cnt_inst + cnt_t'(1);
        2'b01:   cnt_inst <= cnt_inst - cnt_t'(1);
        default: ;
      endcase
      case ({inc_data, hit_data})
        2'b10:   cnt_data <= cnt_data + cnt_t'(1);
        2'b01:   cnt_data <= cnt_data - cnt_t'(1);
        default: ;
      endcase
    end
  end

  // R routing: steer each beat to its port by rid, flag bad beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready           <= 1'b0;
      inst_sram_data_ok <= 1'b0;
      data_sram_data_ok <= 1'b0;
      inst_sram_rdata   <= '0;
      data_sram_rdata   <= '0;
      rd_err            <= 1'b0;
    end else begin
      r_ready           <= 1'b1;
      inst_sram_data_ok <= hit_inst;
      data_sram_data_ok <= hit_data;
      if (hit_inst) inst_sram_rdata <= axi.rdata;
      if (hit_data) data_sram_rdata <= axi.rdata;
      if (bad_beat) rd_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction model.
module tb_axi_rd_arbiter;
  localparam logic [3:0] IID = 4'd0;
  localparam logic [3:0] DID = 4'd1;

  logic        clk;
  logic        reset;
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wr_pending;
  logic [31:0] wr_pending_addr;
  logic        rd_err;

  axi_rd_arbiter_if axi ();

  axi_rd_arbiter #(
    .MAX_OUTST(2), .INST_ID(IID), .DATA_ID(DID)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inst_sram_req(inst_sram_req),
    .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req),
    .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .wr_pending(wr_pending),
    .wr_pending_addr(wr_pending_addr),
    .rd_err(rd_err),
    .axi(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic idle_in();
    inst_sram_req   = 1'b0;
    inst_sram_size  = 2'd2;
    inst_sram_addr  = 32'h0;
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'd2;
    data_sram_addr  = 32'h0;
    wr_pending      = 1'b0;
    wr_pending_addr = 32'h0;
    axi.arready     = 1'b0;
    axi.rvalid      = 1'b0;
    axi.rid         = 4'd0;
    axi.rdata       = 32'h0;
    axi.rresp       = 2'b00;
    axi.rlast       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          ir;
    bit          dr;
    bit          dw;
    bit          wp;
    logic [31:0] wa;
    logic [31:0] da;
    bit          ei;
    bit          ed;
  } vec_t;

  vec_t vt[10];

  int          gseq[$];
  int          n;
  int          outst_i;
  int          outst_d;
  int          grants;
  bit          last_d;
  bit          have_pend;
  logic [3:0]  p_id;
  logic [31:0] p_addr;
  logic [2:0]  p_size;
  bit          edok_i;
  bit          edok_d;
  bit          bi;
  bit          bd;
  bit          el_i;
  bit          el_d;
  bit          egi;
  bit          egd;
  bit          gen;
  logic [31:0] sb_i[$];
  logic [31:0] sb_d[$];
  logic [31:0] sl_i[$];
  logic [31:0] sl_d[$];
  logic [31:0] tmp;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with a request held to show it is not accepted.
    reset = 1'b1;
    idle_in();
    inst_sram_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_arvalid", 32'(axi.arvalid), 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_arid", 32'(axi.arid), 0);
    chk("rst_arsize", 32'(axi.arsize), 0);
    chk("rst_rready", 32'(axi.rready), 0);
    chk("rst_iaok", 32'(inst_sram_addr_ok), 0);
    chk("rst_idok", 32'(inst_sram_data_ok), 0);
    chk("rst_ddok", 32'(data_sram_data_ok), 0);
    chk("rst_irdata", inst_sram_rdata, 0);
    chk("rst_rderr", 32'(rd_err), 0);
    chk("const_arlen", 32'(axi.arlen), 0);
    chk("const_arburst", 32'(axi.arburst), 1);
    chk("const_misc",
        32'({axi.arlock, axi.arcache, axi.arprot}), 0);
    reset = 1'b0;

    // Eligibility and first-grant table (rr_last=DATA after reset).
    vt[0] = '{1, 0, 0, 0, 32'h0,   32'h200, 1, 0};
    vt[1] = '{0, 1, 0, 0, 32'h0,   32'h200, 0, 1};
    vt[2] = '{1, 1, 0, 0, 32'h0,   32'h200, 1, 0};
    vt[3] = '{0, 1, 1, 0, 32'h0,   32'h200, 0, 0};
    vt[4] = '{0, 1, 0, 1, 32'h100, 32'h103, 0, 0};
    vt[5] = '{0, 1, 0, 1, 32'h100, 32'h104, 0, 1};
    vt[6] = '{0, 1, 0, 0, 32'h100, 32'h100, 0, 1};
    vt[7] = '{1, 1, 0, 1, 32'h100, 32'h100, 1, 0};
    vt[8] = '{0, 0, 0, 1, 32'h100, 32'h100, 0, 0};
    vt[9] = '{1, 1, 1, 0, 32'h0,   32'h300, 1, 0};
    for (int i = 0; i < 10; i++) begin
      do_reset();
      inst_sram_req   = vt[i].ir;
      inst_sram_addr  = 32'h1000;
      data_sram_req   = vt[i].dr;
      data_sram_wr    = vt[i].dw;
      wr_pending      = vt[i].wp;
      wr_pending_addr = vt[i].wa;
      data_sram_addr  = vt[i].da;
      #1;
      chk($sformatf("vec%0d_iaok", i),
          32'(inst_sram_addr_ok), 32'(vt[i].ei));
      chk($sformatf("vec%0d_daok", i),
          32'(data_sram_addr_ok), 32'(vt[i].ed));
    end

    // Single inst read end to end.
    do_reset();
    axi.arready    = 1'b1;
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1FC0_0000;
    inst_sram_size = 2'd2;
    #1;
    chk("t1_aok", 32'(inst_sram_addr_ok), 1);
    chk("t1_arv_t0", 32'(axi.arvalid), 0);
    @(negedge clk);
    inst_sram_req = 1'b0;
    #1;
    chk("t1_arv_t1", 32'(axi.arvalid), 1);
    chk("t1_araddr", axi.araddr, 32'h1FC0_0000);
    chk("t1_arid", 32'(axi.arid), 32'(IID));
    chk("t1_arsize", 32'(axi.arsize), 2);
    chk("t1_aok_wait", 32'(inst_sram_addr_ok), 0);
    @(negedge clk);
    #1;
    chk("t1_arv_t2", 32'(axi.arvalid), 0);
    @(negedge clk);
    @(negedge clk);
    axi.rvalid = 1'b1;
    axi.rid    = IID;
    axi.rdata  = 32'h2402_0001;
    @(negedge clk);
    axi.rvalid = 1'b0;
    axi.rdata  = 32'h0;
    #1;
    chk("t1_idok", 32'(inst_sram_data_ok), 1);
    chk("t1_ddok", 32'(data_sram_data_ok), 0);
    chk("t1_rdata", inst_sram_rdata, 32'h2402_0001);
    @(negedge clk);
    #1;
    chk("t1_idok_drop", 32'(inst_sram_data_ok), 0);
    chk("t1_rdata_hold", inst_sram_rdata, 32'h2402_0001);

    // Both ports requesting every cycle: grants alternate.
    do_reset();
    axi.arready    = 1'b1;
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1000;
    data_sram_req  = 1'b1;
    data_sram_addr = 32'h2000;
    gseq.delete();
    for (int i = 0; i < 10; i++) begin
      #1;
      if (inst_sram_addr_ok) gseq.push_back(0);
      if (data_sram_addr_ok) gseq.push_back(1);
      @(negedge clk);
    end
    chk("t2_ngrant", 32'(gseq.size()), 4);
    if (gseq.size() == 4)
      for (int k = 0; k < 4; k++)
        chk($sformatf("t2_g%0d", k), 32'(gseq[k]), 32'(k % 2));
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    axi.rvalid = 1'b1;
    axi.rid    = DID;
    axi.rdata  = 32'hD0D0_0001;
    @(negedge clk);
    axi.rvalid = 1'b0;
    #1;
    chk("t2_ddok", 32'(data_sram_data_ok), 1);
    chk("t2_idok0", 32'(inst_sram_data_ok), 0);
    chk("t2_drdata", data_sram_rdata, 32'hD0D0_0001);
    axi.rvalid = 1'b1;
    axi.rid    = IID;
    axi.rdata  = 32'h1010_0001;
    @(negedge clk);
    axi.rvalid = 1'b0;
    #1;
    chk("t2_idok", 32'(inst_sram_data_ok), 1);
    chk("t2_ddok0", 32'(data_sram_data_ok), 0);
    chk("t2_irdata", inst_sram_rdata, 32'h1010_0001);

    // Outstanding limit: third inst read waits for a returned beat.
    do_reset();
    axi.arready    = 1'b1;
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h3000;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (inst_sram_addr_ok) n++;
      @(negedge clk);
    end
    chk("t3_nacc", 32'(n), 2);
    axi.rvalid = 1'b1;
    axi.rid    = IID;
    axi.rdata  = 32'h3333_0000;
    #1;
    chk("t3_aok_full", 32'(inst_sram_addr_ok), 0);
    @(negedge clk);
    axi.rvalid = 1'b0;
    #1;
    chk("t3_aok_freed", 32'(inst_sram_addr_ok), 1);
    chk("t3_idok", 32'(inst_sram_data_ok), 1);

    // Read-after-write hold-off on a matching word.
    do_reset();
    axi.arready     = 1'b1;
    data_sram_req   = 1'b1;
    data_sram_addr  = 32'h103;
    wr_pending      = 1'b1;
    wr_pending_addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t4_hold%0d", i), 32'(data_sram_addr_ok), 0);
      @(negedge clk);
    end
    wr_pending = 1'b0;
    #1;
    chk("t4_release", 32'(data_sram_addr_ok), 1);
    do_reset();
    data_sram_req   = 1'b1;
    data_sram_addr  = 32'h104;
    wr_pending      = 1'b1;
    wr_pending_addr = 32'h100;
    #1;
    chk("t4_other_word", 32'(data_sram_addr_ok), 1);

    // AR held while arready stays low.
    do_reset();
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h5000;
    #1;
    chk("t5_aok", 32'(inst_sram_addr_ok), 1);
    @(negedge clk);
    inst_sram_addr = 32'h5004;
    data_sram_req  = 1'b1;
    data_sram_addr = 32'h6000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_arvalid", 32'(axi.arvalid), 1);
      chk("t5_araddr", axi.araddr, 32'h5000);
      chk("t5_arid", 32'(axi.arid), 32'(IID));
      chk("t5_aok_i", 32'(inst_sram_addr_ok), 0);
      chk("t5_aok_d", 32'(data_sram_addr_ok), 0);
      @(negedge clk);
    end
    axi.arready = 1'b1;
    #1;
    chk("t5_arv_hs", 32'(axi.arvalid), 1);
    @(negedge clk);
    axi.arready   = 1'b0;
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    #1;
    chk("t5_arv_done", 32'(axi.arvalid), 0);

    // Unexpected beat, then reset in the middle of AR_WAIT.
    do_reset();
    @(negedge clk);
    axi.rvalid = 1'b1;
    axi.rid    = DID;
    axi.rdata  = 32'h0000_0BAD;
    @(negedge clk);
    axi.rvalid = 1'b0;
    #1;
    chk("t6_ddok", 32'(data_sram_data_ok), 0);
    chk("t6_rderr", 32'(rd_err), 1);
    chk("t6_drdata", data_sram_rdata, 0);
    @(negedge clk);
    #1;
    chk("t6_sticky", 32'(rd_err), 1);
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h7000;
    @(negedge clk);
    #1;
    chk("t6_arv", 32'(axi.arvalid), 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("t6r_arvalid", 32'(axi.arvalid), 0);
    chk("t6r_araddr", axi.araddr, 0);
    chk("t6r_arid", 32'(axi.arid), 0);
    chk("t6r_rready", 32'(axi.rready), 0);
    chk("t6r_rderr", 32'(rd_err), 0);
    chk("t6r_iaok", 32'(inst_sram_addr_ok), 0);

    // Randomized traffic against a transaction-level model.
    do_reset();
    outst_i   = 0;
    outst_d   = 0;
    grants    = 0;
    last_d    = 1'b1;
    have_pend = 1'b0;
    edok_i    = 1'b0;
    edok_d    = 1'b0;
    for (int c = 0; c < 3300; c++) begin
      @(negedge clk);
      gen = (c < 3000);
      inst_sram_req   = gen && ($urandom % 3 != 0);
      tmp             = $urandom;
      inst_sram_addr  = tmp;
      inst_sram_size  = 2'($urandom);
      data_sram_req   = gen && ($urandom % 2 == 0);
      data_sram_wr    = ($urandom % 4 == 0);
      data_sram_size  = 2'($urandom);
      data_sram_addr  = 32'h100 + 32'($urandom % 32);
      wr_pending      = ($urandom % 2 == 0);
      wr_pending_addr = 32'h100 + 32'($urandom % 32);
      axi.arready     = ($urandom % 3 != 0);
      axi.rvalid      = 1'b0;
      axi.rresp       = 2'b00;
      bi = 1'b0;
      bd = 1'b0;
      if (axi.rready && ($urandom % 2 == 0)) begin
        if (sl_i.size() > 0
            && (sl_d.size() == 0 || $urandom % 2 == 0)) begin
          axi.rvalid = 1'b1;
          axi.rid    = IID;
          axi.rdata  = fdat(sl_i.pop_front());
          bi = 1'b1;
        end else if (sl_d.size() > 0) begin
          axi.rvalid = 1'b1;
          axi.rid    = DID;
          axi.rdata  = fdat(sl_d.pop_front());
          bd = 1'b1;
        end
      end
      #1;
      chk("r_rready", 32'(axi.rready), 1);
      chk("r_idok", 32'(inst_sram_data_ok), 32'(edok_i));
      chk("r_ddok", 32'(data_sram_data_ok), 32'(edok_d));
      if (inst_sram_data_ok && sb_i.size() > 0)
        chk("r_irdata", inst_sram_rdata, fdat(sb_i.pop_front()));
      if (data_sram_data_ok && sb_d.size() > 0)
        chk("r_drdata", data_sram_rdata, fdat(sb_d.pop_front()));
      el_i = inst_sram_req && (outst_i < 2);
      el_d = data_sram_req && !data_sram_wr && (outst_d < 2)
          && !(wr_pending
               && wr_pending_addr[31:2] == data_sram_addr[31:2]);
      egi = !have_pend && el_i && (!el_d || last_d);
      egd = !have_pend && el_d && (!el_i || !last_d);
      chk("r_iaok", 32'(inst_sram_addr_ok), 32'(egi));
      chk("r_daok", 32'(data_sram_addr_ok), 32'(egd));
      chk("r_arvalid", 32'(axi.arvalid), 32'(have_pend));
      if (have_pend && axi.arvalid) begin
        chk("r_araddr", axi.araddr, p_addr);
        chk("r_arid", 32'(axi.arid), 32'(p_id));
        chk("r_arsize", 32'(axi.arsize), 32'(p_size));
        if (axi.arready) begin
          if (p_id == IID) sl_i.push_back(p_addr);
          else sl_d.push_back(p_addr);
          have_pend = 1'b0;
        end
      end
      if (egi) begin
        have_pend = 1'b1;
        p_id      = IID;
        p_addr    = inst_sram_addr;
        p_size    = {1'b0, inst_sram_size};
        sb_i.push_back(inst_sram_addr);
        outst_i++;
        last_d = 1'b0;
        grants++;
      end else if (egd) begin
        have_pend = 1'b1;
        p_id      = DID;
        p_addr    = data_sram_addr;
        p_size    = {1'b0, data_sram_size};
        sb_d.push_back(data_sram_addr);
        outst_d++;
        last_d = 1'b1;
        grants++;
      end
      if (bi) outst_i--;
      if (bd) outst_d--;
      edok_i = bi;
      edok_d = bd;
    end
    @(negedge clk);
    #1;
    chk("r_drain_i", 32'(outst_i), 0);
    chk("r_drain_d", 32'(outst_d), 0);
    chk("r_sb_i", 32'(sb_i.size()), 0);
    chk("r_sb_d", 32'(sb_d.size()), 0);
    chk("r_rderr", 32'(rd_err), 0);
    chk("r_progress", 32'(grants > 300), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
